// File: rtl/dot_pkg.sv
// Shared constants and types for the Q16.16 dot-product accelerator.
package dot_pkg;

    // Number of fractional bits in the Q16.16 format
    localparam int FRAC_BITS = 16;

    // Slave register map (word offsets)
    localparam logic [3:0] REG_START  = 4'd0;
    localparam logic [3:0] REG_WBASE  = 4'd1;
    localparam logic [3:0] REG_ABASE  = 4'd2;
    localparam logic [3:0] REG_LEN    = 4'd3;
    localparam logic [3:0] REG_STATUS = 4'd4;

    // Job sequencer states
    typedef enum logic [2:0] {
        IDLE,
        RD_W,
        WAIT_W,
        RD_A,
        WAIT_A,
        MAC,
        DONE
    } state_t;

endpackage

// File: rtl/q16_mul.sv
// Combinational signed Q16.16 multiply; keeps product bits [47:16].
module q16_mul
    import dot_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic [63:0] prod;

    // Sign-extend both operands so the low 64 bits of the unsigned product equal the signed product
    assign prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign p    = 32'(prod >> FRAC_BITS);

endmodule

// File: rtl/dot_accel.sv
// Avalon-MM dot-product accelerator: fetches N weight/activation word pairs
// from memory, accumulates their Q16.16 products and exposes the sum to the CPU.
module dot_accel
    import dot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    state_t      state;
    state_t      next_state;
    logic [31:0] w_base;
    logic [31:0] a_base;
    logic [31:0] len;
    logic [31:0] idx;
    logic [31:0] acc;
    logic [31:0] result;
    logic [31:0] w_word;
    logic [31:0] a_word;
    logic [31:0] term;
    logic [31:0] acc_sum;
    logic        busy;
    logic        start;
    logic        status_read;
    logic        last;

    q16_mul u_mul (
        .a (w_word),
        .b (a_word),
        .p (term)
    );

    // DONE is not busy: that is the cycle in which stalled CPU accesses are released
    assign busy        = (state != IDLE) && (state != DONE);
    assign start       = slave_write && (slave_address == REG_START) && !busy;
    assign status_read = slave_read && (slave_address == REG_STATUS);
    assign slave_waitrequest = busy && (slave_read || slave_write) && !status_read;

    assign acc_sum = acc + term;
    // Widened compare so idx+1 cannot wrap when len is near 2^32
    assign last    = (({1'b0, idx} + 33'd1) >= {1'b0, len});

    assign master_write     = 1'b0;
    assign master_writedata = 32'd0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the fetch/multiply/accumulate sequence
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == 32'd0) ? DONE : RD_W;
                end
            end
            RD_W: begin
                if (!master_waitrequest) begin
                    next_state = WAIT_W;
                end
            end
            WAIT_W: begin
                if (master_readdatavalid) begin
                    next_state = RD_A;
                end
            end
            RD_A: begin
                if (!master_waitrequest) begin
                    next_state = WAIT_A;
                end
            end
            WAIT_A: begin
                if (master_readdatavalid) begin
                    next_state = MAC;
                end
            end
            MAC: begin
                next_state = last ? DONE : RD_W;
            end
            DONE: begin
                if (start) begin
                    next_state = (len == 32'd0) ? DONE : RD_W;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Memory master request: address held steady by state/idx while the fabric stalls
    always_comb begin
        master_read    = 1'b0;
        master_address = 32'd0;
        case (state)
            RD_W: begin
                master_read    = 1'b1;
                master_address = w_base + (idx << 2);
            end
            RD_A: begin
                master_read    = 1'b1;
                master_address = a_base + (idx << 2);
            end
            default: ;
        endcase
    end

    // CPU read mux; a released read of offset 0 in DONE sees the freshly written result
    always_comb begin
        slave_readdata = 32'd0;
        if (slave_read) begin
            case (slave_address)
                REG_START:  slave_readdata = result;
                REG_WBASE:  slave_readdata = w_base;
                REG_ABASE:  slave_readdata = a_base;
                REG_LEN:    slave_readdata = len;
                REG_STATUS: slave_readdata = {31'd0, busy};
                default:    slave_readdata = 32'd0;
            endcase
        end
    end

    // Configuration registers; writes are only accepted while no job is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_base <= 32'd0;
            a_base <= 32'd0;
            len    <= 32'd0;
        end else if (slave_write && !busy) begin
            case (slave_address)
                REG_WBASE: w_base <= slave_writedata;
                REG_ABASE: a_base <= slave_writedata;
                REG_LEN:   len    <= slave_writedata;
                default: ;
            endcase
        end
    end

    // Datapath: operand capture, accumulation, index and result update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= 32'd0;
            acc    <= 32'd0;
            result <= 32'd0;
            w_word <= 32'd0;
            a_word <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc <= 32'd0;
                        idx <= 32'd0;
                        if (len == 32'd0) begin
                            result <= 32'd0;
                        end
                    end
                end
                WAIT_W: begin
                    if (master_readdatavalid) begin
                        w_word <= master_readdata;
                    end
                end
                WAIT_A: begin
                    if (master_readdatavalid) begin
                        a_word <= master_readdata;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx + 32'd1;
                    if (last) begin
                        result <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_accel.sv
// Scoreboard-based bench for dot_accel with a simple stalling memory model.
module tb_dot_accel;
    import dot_pkg::*;

    localparam int LIMIT = 500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem [bit [31:0]];
    logic [31:0] exp_addr[$];
    logic [31:0] sb_val[$];
    string       sb_name[$];

    int          read_pulses = 0;
    int          stall_cfg   = 0;
    int          stall_left  = 0;
    int          mem_latency = 1;
    int          lat_left    = 0;
    logic [31:0] pend_data   = 32'd0;

    always #5 clk = ~clk;

    dot_accel dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_readdata       (slave_readdata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic failNow(input string name, input string what);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Memory responder: optional waitrequest stall, fixed readdatavalid latency, address checks
    initial begin
        logic        acc_now;
        logic [31:0] addr_now;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = 32'd0;
        forever begin
            @(negedge clk);
            acc_now  = master_read && !master_waitrequest;
            addr_now = master_address;
            if (master_read && master_waitrequest) begin
                if (exp_addr.size() > 0) checkOutput("addr_stable", addr_now, exp_addr[0]);
                if (stall_left > 0) stall_left--;
            end
            @(posedge clk);
            #1;
            master_readdatavalid = 1'b0;
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = pend_data;
                end
            end
            if (acc_now) begin
                read_pulses++;
                if (exp_addr.size() > 0) checkOutput("fetch_addr", addr_now, exp_addr.pop_front());
                else failNow("fetch_addr", $sformatf("unexpected read at 0x%08h, expected none", addr_now));
                pend_data  = mem.exists(addr_now) ? mem[addr_now] : 32'hDEAD_BEEF;
                lat_left   = mem_latency;
                stall_left = stall_cfg;
            end
            master_waitrequest = (stall_left > 0);
        end
    end

    // Scoreboard monitor: every completed CPU read is compared to the oldest expectation
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (slave_read && !slave_waitrequest) begin
                if (sb_val.size() == 0) begin
                    failNow("sb_unexpected", $sformatf("read data 0x%08h, expected no read", slave_readdata));
                end else begin
                    e  = sb_val.pop_front();
                    nm = sb_name.pop_front();
                    checkOutput(nm, slave_readdata, e);
                end
            end
        end
    end

    // Watchdog against a hung handshake
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        int cyc = 0;
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        while (slave_waitrequest && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        if (slave_waitrequest) failNow("write_timeout", $sformatf("waitrequest still 1 at offset %0d, expected 0", a));
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic busRead(input logic [3:0] a, input logic [31:0] e, input string nm, output int stalls);
        int cyc = 0;
        sb_val.push_back(e);
        sb_name.push_back(nm);
        slave_address = a;
        slave_read    = 1'b1;
        @(negedge clk);
        while (slave_waitrequest && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        if (slave_waitrequest) begin
            failNow({nm, "_timeout"}, "waitrequest still 1, expected 0");
            void'(sb_val.pop_back());
            void'(sb_name.pop_back());
        end
        stalls = cyc;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] wb, input logic [31:0] ab);
        busWrite(REG_WBASE, wb);
        busWrite(REG_ABASE, ab);
        busWrite(REG_LEN, 32'(n));
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(wb + 32'(4 * i));
            exp_addr.push_back(ab + 32'(4 * i));
        end
        busWrite(REG_START, 32'hA5A5_0000);
    endtask

    initial begin
        int s;
        int p0;
        int cyc;

        rst_n           = 1'b0;
        slave_address   = 4'd0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_master_read", {31'd0, master_read}, 32'd0);
        checkOutput("reset_master_addr", master_address, 32'd0);
        checkOutput("reset_slave_wait", {31'd0, slave_waitrequest}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        busRead(REG_START, 32'd0, "reset_result", s);

        // N=3: 1.0*0.5 + 2.0*0.5 + 3.0*0.5 = 3.0
        mem[32'h1000] = 32'h0001_0000; mem[32'h1004] = 32'h0002_0000; mem[32'h1008] = 32'h0003_0000;
        mem[32'h2000] = 32'h0000_8000; mem[32'h2004] = 32'h0000_8000; mem[32'h2008] = 32'h0000_8000;
        p0 = read_pulses;
        applyStimulus(3, 32'h1000, 32'h2000);
        busRead(REG_START, 32'h0003_0000, "n3_result", s);
        checkOutput("n3_pulses", 32'(read_pulses - p0), 32'd6);
        busRead(REG_STATUS, 32'd0, "n3_status_idle", s);
        busRead(REG_WBASE, 32'h1000, "keep_wbase", s);
        busRead(REG_ABASE, 32'h2000, "keep_abase", s);
        busRead(REG_LEN, 32'd3, "keep_len", s);

        // N=1: -1.0 * 2.0 = -2.0
        mem[32'h3000] = 32'hFFFF_0000;
        mem[32'h3100] = 32'h0002_0000;
        applyStimulus(1, 32'h3000, 32'h3100);
        busRead(REG_START, 32'hFFFE_0000, "n1_result", s);

        // N=0: immediate zero result, no memory traffic
        p0 = read_pulses;
        applyStimulus(0, 32'h3000, 32'h3100);
        busRead(REG_START, 32'd0, "n0_result", s);
        checkOutput("n0_no_stall", 32'(s), 32'd0);
        checkOutput("n0_pulses", 32'(read_pulses - p0), 32'd0);

        // Stalling memory: 5 waitrequest cycles per read, valid 3 cycles after acceptance
        mem[32'h9000] = 32'h0001_0000; mem[32'h9004] = 32'h0002_0000; mem[32'h9008] = 32'h0003_0000;
        mem[32'hA000] = 32'h0000_8000; mem[32'hA004] = 32'h0000_8000; mem[32'hA008] = 32'h0000_8000;
        stall_cfg          = 5;
        stall_left         = 5;
        mem_latency        = 3;
        master_waitrequest = 1'b1;
        applyStimulus(3, 32'h9000, 32'hA000);
        busRead(REG_START, 32'h0003_0000, "stall_result", s);
        stall_cfg          = 0;
        stall_left         = 0;
        mem_latency        = 1;
        master_waitrequest = 1'b0;

        // N=4 mixed signs: 3.0 - 1.5 - 8.0 + 2^-16 = 0xFFF98001
        mem[32'h4000] = 32'h0001_8000; mem[32'h4004] = 32'hFFFF_8000;
        mem[32'h4008] = 32'h0004_0000; mem[32'h400C] = 32'h0000_0001;
        mem[32'h5000] = 32'h0002_0000; mem[32'h5004] = 32'h0003_0000;
        mem[32'h5008] = 32'hFFFE_0000; mem[32'h500C] = 32'h0001_0000;
        applyStimulus(4, 32'h4000, 32'h5000);
        busRead(REG_STATUS, 32'd1, "busy_status", s);
        checkOutput("status_no_stall", 32'(s), 32'd0);
        busRead(REG_START, 32'hFFF9_8001, "n4_result", s);
        checkOutput("result_stalled", (s > 0) ? 32'd1 : 32'd0, 32'd1);

        // Reset during WAIT_A of an N=4 job; the late readdatavalid must be ignored
        for (int i = 0; i < 4; i++) begin
            mem[32'h6000 + 32'(4 * i)] = 32'h0001_0000;
            mem[32'h7000 + 32'(4 * i)] = 32'h0001_0000;
        end
        mem_latency = 3;
        p0 = read_pulses;
        applyStimulus(4, 32'h6000, 32'h7000);
        cyc = 0;
        @(negedge clk);
        while (read_pulses < p0 + 2 && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        if (read_pulses < p0 + 2) failNow("abort_wait", "second fetch not seen, expected it");
        rst_n = 1'b0;
        #1;
        checkOutput("abort_master_read", {31'd0, master_read}, 32'd0);
        checkOutput("abort_master_addr", master_address, 32'd0);
        checkOutput("abort_slave_wait", {31'd0, slave_waitrequest}, 32'd0);
        sb_val.push_back(32'd0);
        sb_name.push_back("abort_result");
        slave_address = REG_START;
        slave_read    = 1'b1;
        @(negedge clk);
        #1;
        slave_read = 1'b0;
        rst_n      = 1'b1;
        exp_addr.delete();
        repeat (6) @(posedge clk);
        #1;
        mem_latency = 1;
        busRead(REG_STATUS, 32'd0, "abort_status", s);
        busRead(REG_LEN, 32'd0, "abort_len", s);
        busRead(REG_WBASE, 32'd0, "abort_wbase", s);

        // Fresh N=1 job after abort: 3.0 * -1.0 = -3.0
        mem[32'h8000] = 32'h0003_0000;
        mem[32'h8100] = 32'hFFFF_0000;
        p0 = read_pulses;
        applyStimulus(1, 32'h8000, 32'h8100);
        busRead(REG_START, 32'hFFFD_0000, "post_abort_result", s);
        checkOutput("post_abort_pulses", 32'(read_pulses - p0), 32'd2);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb_val.size()), 32'd0);
        checkOutput("addr_drained", 32'(exp_addr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
